// File: rtl/color_freq_sampler_pkg.sv
// Shared FSM states, filter select codes and colour constants for the colour-sensor sampler.
package color_freq_sampler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_DIV_LOAD,
        ST_DIV_WAIT,
        ST_DIV_REL,
        ST_DONE
    } state_t;

    // Measurement order is the enum order: clear, red, green, blue.
    typedef enum logic [1:0] {
        FILT_CLEAR,
        FILT_RED,
        FILT_GREEN,
        FILT_BLUE
    } filter_t;

    localparam logic [1:0] COL_RED   = 2'd0;
    localparam logic [1:0] COL_GREEN = 2'd1;
    localparam logic [1:0] COL_BLUE  = 2'd2;

    localparam logic [7:0] PERC_FULL = 8'd100;

    // TCS3200 {S2,S3} select for each filter.
    function automatic logic [1:0] s2s3_code(input filter_t f);
        case (f)
            FILT_CLEAR: return 2'b10;
            FILT_RED:   return 2'b00;
            FILT_GREEN: return 2'b11;
            default:    return 2'b01;
        endcase
    endfunction

endpackage

// File: rtl/color_freq_sampler_edge_counter.sv
// Synchronises the asynchronous sensor output, detects rising edges and counts them
// into a saturating counter while enabled; clr empties the counter.
module color_freq_sampler_edge_counter #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [2:0] sync_q;
    logic       rise;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && rise && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/color_freq_sampler.sv
// TCS3200 front end: measures clear/red/green/blue pulse counts and obtains colour percentages
// from an external divider. Optional divider watchdog enabled by FREQ_SAMPLER_TIMEOUT_EN.
module color_freq_sampler
    import color_freq_sampler_pkg::*;
#(
    parameter int CNT_W      = 10,
    parameter int SETTLE_CYC = 10000,
    parameter int GATE_CYC   = 100000
`ifdef FREQ_SAMPLER_TIMEOUT_EN
    ,
    parameter int DIV_TMO    = 256
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sensor_out,
    output logic             filt_s2,
    output logic             filt_s3,
    output logic             div_start,
    output logic [CNT_W-1:0] div_freq,
    output logic [CNT_W-1:0] div_clear,
    input  logic             div_done,
    input  logic [7:0]       div_perc,
    output logic [7:0]       red_perc,
    output logic [7:0]       green_perc,
    output logic [7:0]       blue_perc,
    output logic             valid,
    output logic             busy,
    output logic             err
);

    state_t           state, state_nx;
    logic [31:0]      tmr;
    filter_t          filt_idx, cap_idx;
    logic             cap_q;
    logic [1:0]       col_idx;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] ec_count;
    logic [7:0]       res_r, res_g, res_b;
    logic             settle_end, gate_end, guard_zero, guard_full, div_timeout;
    logic             res_wr;
    logic [7:0]       res_val;

    color_freq_sampler_edge_counter #(.CNT_W(CNT_W)) u_edge_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sensor_out),
        .en    (state == ST_GATE),
        .clr   ((state == ST_IDLE) || (state == ST_SETTLE)),
        .count (ec_count)
    );

    assign {filt_s2, filt_s3} = s2s3_code(filt_idx);
    assign settle_end = (tmr == 32'(SETTLE_CYC - 1));
    assign gate_end   = (tmr == 32'(GATE_CYC - 1));

    // Operands are selected by colour index, so they hold still for the whole division.
    assign div_freq   = cnt_q[col_idx + 2'd1];
    assign div_clear  = cnt_q[FILT_CLEAR];
    // The divider never terminates on a zero divisor, so that case must be caught first.
    assign guard_zero = (div_clear == '0);
    assign guard_full = (div_freq >= div_clear);

`ifdef FREQ_SAMPLER_TIMEOUT_EN
    assign div_timeout = (state == ST_DIV_WAIT) && !div_done && (tmr == 32'(DIV_TMO - 1));
`else
    assign div_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx  = state;
        busy      = 1'b1;
        valid     = 1'b0;
        div_start = 1'b0;
        res_wr    = 1'b0;
        res_val   = '0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = ST_SETTLE;
            end
            ST_SETTLE: if (settle_end) state_nx = ST_GATE;
            ST_GATE: begin
                if (gate_end) state_nx = (filt_idx == FILT_BLUE) ? ST_DIV_LOAD : ST_SETTLE;
            end
            ST_DIV_LOAD: begin
                if (guard_zero || guard_full) begin
                    res_wr   = 1'b1;
                    res_val  = guard_zero ? 8'd0 : PERC_FULL;
                    state_nx = ST_DIV_REL;
                end else begin
                    state_nx = ST_DIV_WAIT;
                end
            end
            ST_DIV_WAIT: begin
                div_start = 1'b1;
                if (div_done) begin
                    res_wr   = 1'b1;
                    res_val  = div_perc;
                    state_nx = ST_DIV_REL;
                end else if (div_timeout) begin
                    res_wr   = 1'b1;
                    res_val  = 8'hFF;
                    state_nx = ST_DIV_REL;
                end
            end
            ST_DIV_REL: state_nx = (col_idx == COL_BLUE) ? ST_DONE : ST_DIV_LOAD;
            ST_DONE: begin
                valid    = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr        <= '0;
            filt_idx   <= FILT_CLEAR;
            cap_idx    <= FILT_CLEAR;
            cap_q      <= 1'b0;
            col_idx    <= COL_RED;
            // NOTE: the count array is small and must read as zero after reset, so it is reset explicitly.
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            res_r      <= '0;
            res_g      <= '0;
            res_b      <= '0;
            red_perc   <= '0;
            green_perc <= '0;
            blue_perc  <= '0;
        end else begin
            tmr     <= (state_nx != state) ? 32'd0 : tmr + 32'd1;
            // The final gate edge lands in the counter on the closing clock, so capture one cycle later.
            cap_q   <= (state == ST_GATE) && gate_end;
            cap_idx <= filt_idx;
            if (cap_q) cnt_q[cap_idx] <= ec_count;

            if (res_wr) begin
                case (col_idx)
                    COL_RED:   res_r <= res_val;
                    COL_GREEN: res_g <= res_val;
                    default:   res_b <= res_val;
                endcase
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        filt_idx <= FILT_CLEAR;
                        col_idx  <= COL_RED;
                    end
                end
                ST_GATE: begin
                    if (gate_end && (filt_idx != FILT_BLUE)) filt_idx <= filter_t'(filt_idx + 2'd1);
                end
                ST_DIV_REL: begin
                    if (col_idx == COL_BLUE) begin
                        red_perc   <= res_r;
                        green_perc <= res_g;
                        blue_perc  <= res_b;
                    end else begin
                        col_idx <= col_idx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FREQ_SAMPLER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        err <= 1'b0;
        else if (state == ST_IDLE && start) err <= 1'b0;
        else if (div_timeout)              err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_color_freq_sampler.sv
// Directed bench for color_freq_sampler with a cycle-timed sensor model and a simple divider model.
module tb_color_freq_sampler;

    localparam int S = 20;
    localparam int G = 1100;
`ifdef FREQ_SAMPLER_TIMEOUT_EN
    localparam int TMO = 40;
`endif

    logic       clk = 1'b0;
    logic       rst_n, start, sensor_out, div_done, div_hang;
    logic       filt_s2, filt_s3, div_start, valid, busy, err;
    logic [9:0] div_freq, div_clear;
    logic [7:0] div_perc, red_perc, green_perc, blue_perc;

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;
    int n_rises = 0;
    int n_unstable = 0;
    int dlat = 0;
    logic       ds_prev = 1'b0;
    logic [9:0] hold_f, hold_c;

    always #5 clk = ~clk;

    color_freq_sampler #(
        .CNT_W      (10),
        .SETTLE_CYC (S),
        .GATE_CYC   (G)
`ifdef FREQ_SAMPLER_TIMEOUT_EN
        ,
        .DIV_TMO    (TMO)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sensor_out (sensor_out),
        .filt_s2    (filt_s2),
        .filt_s3    (filt_s3),
        .div_start  (div_start),
        .div_freq   (div_freq),
        .div_clear  (div_clear),
        .div_done   (div_done),
        .div_perc   (div_perc),
        .red_perc   (red_perc),
        .green_perc (green_perc),
        .blue_perc  (blue_perc),
        .valid      (valid),
        .busy       (busy),
        .err        (err)
    );

    // Divider model: answers freq*100/clear five cycles after Start, clears when Start drops.
    always @(posedge clk) begin
        #1;
        if (!div_start) begin
            div_done = 1'b0;
            dlat     = 0;
        end else if (!div_hang) begin
            dlat++;
            if (dlat == 5 && div_clear != 0) begin
                div_perc = 8'((32'(div_freq) * 100) / 32'(div_clear));
                div_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (valid) n_valid++;
        if (div_start && !ds_prev) begin
            n_rises++;
            hold_f = div_freq;
            hold_c = div_clear;
        end else if (div_start && (div_freq !== hold_f || div_clear !== hold_c)) begin
            n_unstable++;
        end
        ds_prev = div_start;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Emits a fixed number of 1-cycle pulses inside each gate window, timed from start acceptance.
    task automatic sensor_run(input string tag, input int nc, input int nr, input int ng,
                              input int nb, input int per);
        int         n [4];
        logic [1:0] code [4];
        n    = '{nc, nr, ng, nb};
        code = '{2'b10, 2'b00, 2'b11, 2'b01};
        for (int f = 0; f < 4; f++) begin
            repeat (S) @(posedge clk);
            #1;
            for (int i = 0; i < G; i++) begin
                sensor_out = (i < n[f] * per) && (i % per == 0);
                if (i == G / 2) check($sformatf("%s filter%0d s2s3", tag, f), {filt_s2, filt_s3}, code[f]);
                @(posedge clk); #1;
            end
            sensor_out = 1'b0;
        end
    endtask

    task automatic wait_valid(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        check({tag, " valid seen"}, 32'(seen), 32'd1);
    endtask

    task automatic run(input string tag, input int nc, input int nr, input int ng, input int nb,
                       input int per, input logic [7:0] er, input logic [7:0] eg,
                       input logic [7:0] eb, input int erises, input logic eerr,
                       input bit poke, input bit start_at_done);
        int v0 = n_valid;
        int r0 = n_rises;
        do_start();
        check({tag, " busy after start"}, 32'(busy), 32'd1);
        check({tag, " err after start"}, 32'(err), 32'd0);
        fork
            sensor_run(tag, nc, nr, ng, nb, per);
            begin
                if (poke) begin
                    repeat (2 * (S + G) + 50) @(posedge clk);
                    #1 start = 1'b1;
                    @(posedge clk); #1 start = 1'b0;
                end
            end
        join
        wait_valid(tag);
        check({tag, " red_perc"}, 32'(red_perc), 32'(er));
        check({tag, " green_perc"}, 32'(green_perc), 32'(eg));
        check({tag, " blue_perc"}, 32'(blue_perc), 32'(eb));
        check({tag, " busy with valid"}, 32'(busy), 32'd1);
        check({tag, " err"}, 32'(err), 32'(eerr));
        if (start_at_done) begin
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        repeat (20) @(negedge clk);
        check({tag, " busy after run"}, 32'(busy), 32'd0);
        check({tag, " valid pulses"}, 32'(n_valid - v0), 32'd1);
        check({tag, " div_start rises"}, 32'(n_rises - r0), 32'(erises));
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        sensor_out = 1'b0;
        div_hang   = 1'b0;
        div_done   = 1'b0;
        div_perc   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset filt_s2", 32'(filt_s2), 32'd1);
        check("reset filt_s3", 32'(filt_s3), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset valid", 32'(valid), 32'd0);
        check("reset div_start", 32'(div_start), 32'd0);
        check("reset red_perc", 32'(red_perc), 32'd0);
        check("reset err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Equal counts on every filter: guards give 100 without dividing.
        run("t1", 100, 100, 100, 100, 10, 8'd100, 8'd100, 8'd100, 0, 1'b0, 1'b0, 1'b0);

        // Normal divisions.
        run("t2", 200, 50, 100, 150, 3, 8'd25, 8'd50, 8'd75, 3, 1'b0, 1'b0, 1'b0);
        check("t2 last divisor", 32'(hold_c), 32'd200);
        check("t2 last dividend", 32'(hold_f), 32'd150);

        // Zero clear count; also start in the DONE cycle must be ignored.
        run("t3", 0, 50, 10, 5, 3, 8'd0, 8'd0, 8'd0, 0, 1'b0, 1'b0, 1'b1);

        // Red above clear, blue just below.
        run("t4", 200, 300, 20, 199, 3, 8'd100, 8'd10, 8'd99, 2, 1'b0, 1'b0, 1'b0);

        // Start pulsed mid-run is ignored.
        run("t5a", 100, 30, 60, 90, 3, 8'd30, 8'd60, 8'd90, 3, 1'b0, 1'b1, 1'b0);

        // Reset during the red gate window.
        do_start();
        repeat (S + G + S + 100) @(posedge clk);
        #1;
        check("t5b s2s3 before reset", 32'({filt_s2, filt_s3}), 32'd0);
        check("t5b busy before reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5b filt_s2", 32'(filt_s2), 32'd1);
        check("t5b filt_s3", 32'(filt_s3), 32'd0);
        check("t5b busy", 32'(busy), 32'd0);
        check("t5b div_start", 32'(div_start), 32'd0);
        check("t5b red_perc", 32'(red_perc), 32'd0);
        check("t5b green_perc", 32'(green_perc), 32'd0);
        check("t5b blue_perc", 32'(blue_perc), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t5b idle after reset", 32'(busy), 32'd0);

`ifdef FREQ_SAMPLER_TIMEOUT_EN
        // Divider never answers: every colour times out and err sets, then the next run clears it.
        div_hang = 1'b1;
        run("t6", 200, 50, 100, 150, 3, 8'hFF, 8'hFF, 8'hFF, 3, 1'b1, 1'b0, 1'b0);
        check("t6 err sticky", 32'(err), 32'd1);
        div_hang = 1'b0;
        run("t6b", 200, 50, 100, 150, 3, 8'd25, 8'd50, 8'd75, 3, 1'b0, 1'b0, 1'b0);
`endif

        check("operands stable during start", 32'(n_unstable), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
